axi4_write_master: RTL

AXI4_WRITE_MASTER -- requirements
Module: axi4_write_master

---
 rtl/axi4_write_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_write_master.sv
//======================================================================
// Module      : axi4_write_master
// Description : Single-burst AXI4 write master (AW/W/B) with response timeout.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module axi4_write_master #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RESP_TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [DATA_W-1:0]   din_data,
    input  logic [DATA_W/8-1:0] din_strb,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                timeout
);

    localparam logic [2:0]  C_AWSIZE    = 3'($clog2(DATA_W/8));
    localparam logic [1:0]  C_INCR      = 2'b01;
    localparam logic [15:0] C_WAIT_LAST = 16'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [7:0]          awlen_q, awlen_d;
    logic                awvalid_q, awvalid_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [7:0]          beat_q, beat_d;
    logic [15:0]         wait_q, wait_d;
    logic                done_q, done_d;
    logic [1:0]          done_resp_q, done_resp_d;
    logic                timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            beat_q      <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awvalid_q   <= awvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awvalid_d   = awvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        timeout_d   = timeout_q;
        cmd_ready   = 1'b0;
        wvalid      = 1'b0;
        din_ready   = 1'b0;
        wlast       = 1'b0;
        bready      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    awaddr_d  = cmd_addr;
                    awlen_d   = cmd_len;
                    awvalid_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    beat_d    = '0;
                    wait_d    = '0;
                    state_d   = S_XFER;
                end
            end
            S_XFER: begin
                if (!w_done_q) begin
                    wvalid    = din_valid;
                    din_ready = wready;
                end
                wlast = wvalid && (beat_q == awlen_q);
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid && wready) begin
                    if (wlast) begin
                        w_done_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
                // Next-state flags include handshakes completing this cycle.
                if (aw_done_d && w_done_d) begin
                    wait_d  = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    done_d      = 1'b1;
                    done_resp_d = bresp;
                    timeout_d   = 1'b0;
                    state_d     = S_IDLE;
                end else if (wait_q == C_WAIT_LAST) begin
                    done_d      = 1'b1;
                    done_resp_d = 2'b10;
                    timeout_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign awlen     = awlen_q;
    assign awsize    = C_AWSIZE;
    assign awburst   = C_INCR;
    assign wdata     = din_data;
    assign wstrb     = din_strb;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign timeout   = timeout_q;

endmodule

`default_nettype wire
